// File: rtl/ysyx_22041412_div.sv
// Iterative radix-2 restoring divider for RV64M DIV/DIVU/REM/REMU and their W forms.
// Uses the en/ready stall handshake; ready and result are registered.
module ysyx_22041412_div #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic            flush,
  input  logic            w_en,
  input  logic [2:0]      func3,
  input  logic [XLEN-1:0] rsA,
  input  logic [XLEN-1:0] rsB,
  output logic            ready,
  output logic            busy,
  output logic [XLEN-1:0] result
);

  localparam int HW = XLEN / 2;
  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] LAST_D = CW'(XLEN - 1);
  localparam logic [CW-1:0] LAST_W = CW'(HW - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state_reg, state_next;
  logic [XLEN-1:0] quo_reg, quo_next;
  logic [XLEN-1:0] rem_reg, rem_next;
  logic [XLEN-1:0] div_reg, div_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic            w_reg, w_next;
  logic            sel_reg, sel_next;
  logic            qneg_reg, qneg_next;
  logic            rneg_reg, rneg_next;
  logic            ready_reg, ready_next;
  logic [XLEN-1:0] result_reg, result_next;

  // W results are sign-extended from the low half.
  function automatic logic [XLEN-1:0] fmt_w(input logic [XLEN-1:0] x, input logic w);
    fmt_w = w ? {{HW{x[HW-1]}}, x[HW-1:0]} : x;
  endfunction

  // Operand preparation at request time
  logic            is_signed;
  logic [XLEN-1:0] a_ext, b_ext, a_abs, b_abs, min_val, a_pre;
  logic            a_neg, b_neg, div_zero, ovf;

  always_comb begin
    is_signed = ~func3[0];
    if (w_en) begin
      a_ext   = is_signed ? {{HW{rsA[HW-1]}}, rsA[HW-1:0]} : {{HW{1'b0}}, rsA[HW-1:0]};
      b_ext   = is_signed ? {{HW{rsB[HW-1]}}, rsB[HW-1:0]} : {{HW{1'b0}}, rsB[HW-1:0]};
      min_val = {{(HW+1){1'b1}}, {(HW-1){1'b0}}};
    end else begin
      a_ext   = rsA;
      b_ext   = rsB;
      min_val = {1'b1, {(XLEN-1){1'b0}}};
    end
    a_neg    = is_signed & a_ext[XLEN-1];
    b_neg    = is_signed & b_ext[XLEN-1];
    a_abs    = a_neg ? -a_ext : a_ext;
    b_abs    = b_neg ? -b_ext : b_ext;
    div_zero = (b_ext == '0);
    ovf      = is_signed && (a_ext == min_val) && (b_ext == '1);
    // W dividends sit in the upper half so the first shift brings out their MSB.
    a_pre    = w_en ? {a_abs[HW-1:0], {HW{1'b0}}} : a_abs;
  end

  // One restoring step
  logic [XLEN:0]   rem_sh, rem_diff;
  logic            ge;
  logic [XLEN-1:0] rem_step, quo_step, q_fix, r_fix;
  logic [CW-1:0]   cnt_last;

  always_comb begin
    rem_sh   = {rem_reg, quo_reg[XLEN-1]};
    rem_diff = rem_sh - {1'b0, div_reg};
    ge       = (rem_sh >= {1'b0, div_reg});
    rem_step = ge ? rem_diff[XLEN-1:0] : rem_sh[XLEN-1:0];
    quo_step = {quo_reg[XLEN-2:0], ge};
    q_fix    = qneg_reg ? -quo_step : quo_step;
    r_fix    = rneg_reg ? -rem_step : rem_step;
    cnt_last = w_reg ? LAST_W : LAST_D;
  end

  always_comb begin
    state_next  = state_reg;
    quo_next    = quo_reg;
    rem_next    = rem_reg;
    div_next    = div_reg;
    cnt_next    = cnt_reg;
    w_next      = w_reg;
    sel_next    = sel_reg;
    qneg_next   = qneg_reg;
    rneg_next   = rneg_reg;
    ready_next  = 1'b0;
    result_next = result_reg;

    case (state_reg)
      IDLE: begin
        if (en) begin
          w_next    = w_en;
          sel_next  = func3[1];
          qneg_next = a_neg ^ b_neg;
          rneg_next = a_neg;
          div_next  = b_abs;
          rem_next  = '0;
          quo_next  = a_pre;
          cnt_next  = '0;
          if (div_zero) begin
            state_next  = DONE;
            ready_next  = 1'b1;
            result_next = fmt_w(func3[1] ? a_ext : '1, w_en);
          end else if (ovf) begin
            state_next  = DONE;
            ready_next  = 1'b1;
            result_next = fmt_w(func3[1] ? '0 : a_ext, w_en);
          end else begin
            state_next = BUSY;
          end
        end
      end
      BUSY: begin
        rem_next = rem_step;
        quo_next = quo_step;
        if (cnt_reg == cnt_last) begin
          state_next  = DONE;
          ready_next  = 1'b1;
          result_next = fmt_w(sel_reg ? r_fix : q_fix, w_reg);
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase

    // Abort wins over everything, including a start in the same cycle.
    if (flush) begin
      state_next  = IDLE;
      ready_next  = 1'b0;
      result_next = result_reg;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      quo_reg    <= '0;
      rem_reg    <= '0;
      div_reg    <= '0;
      cnt_reg    <= '0;
      w_reg      <= 1'b0;
      sel_reg    <= 1'b0;
      qneg_reg   <= 1'b0;
      rneg_reg   <= 1'b0;
      ready_reg  <= 1'b0;
      result_reg <= '0;
    end else begin
      state_reg  <= state_next;
      quo_reg    <= quo_next;
      rem_reg    <= rem_next;
      div_reg    <= div_next;
      cnt_reg    <= cnt_next;
      w_reg      <= w_next;
      sel_reg    <= sel_next;
      qneg_reg   <= qneg_next;
      rneg_reg   <= rneg_next;
      ready_reg  <= ready_next;
      result_reg <= result_next;
    end
  end

  assign ready  = ready_reg;
  assign busy   = (state_reg == BUSY);
  assign result = result_reg;

endmodule

// File: tb/tb_ysyx_22041412_div.sv
// Self-checking bench for ysyx_22041412_div: directed cases, randomized ops against
// an arithmetic reference model, handshake, flush and reset behaviour.
module tb_ysyx_22041412_div;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        flush = 1'b0;
  logic        w_en = 1'b0;
  logic [2:0]  func3 = 3'b000;
  logic [63:0] rsA = '0;
  logic [63:0] rsB = '0;
  logic        ready;
  logic        busy;
  logic [63:0] result;

  int n_cmp = 0;
  int n_err = 0;
  logic [63:0] last_exp = '0;

  always #5 clk = ~clk;

  ysyx_22041412_div #(.XLEN(64)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .flush(flush), .w_en(w_en),
    .func3(func3), .rsA(rsA), .rsB(rsB),
    .ready(ready), .busy(busy), .result(result)
  );

  typedef struct {
    logic [2:0]  f3;
    logic        w;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp;
    int          lat;
  } vec_t;

  // RISC-V M-extension semantics expressed with plain signed/unsigned arithmetic.
  task automatic ref_model(input logic [2:0] f3, input logic w, input logic [63:0] a,
                           input logic [63:0] b, output logic [63:0] res, output int lat);
    logic signed [31:0] sa32, sb32, t32;
    logic signed [63:0] sa64, sb64, t64;
    logic [31:0] ua32, ub32;
    bit special;
    sa32 = a[31:0]; sb32 = b[31:0]; ua32 = a[31:0]; ub32 = b[31:0];
    sa64 = a; sb64 = b;
    special = 0;
    if (w) begin
      if (ub32 == 0) begin
        special = 1;
        t32 = f3[1] ? sa32 : -32'sd1;
      end else if (!f3[0] && sa32 == 32'sh8000_0000 && sb32 == -32'sd1) begin
        special = 1;
        t32 = f3[1] ? 32'sd0 : sa32;
      end else begin
        case (f3)
          3'b100:  t32 = sa32 / sb32;
          3'b101:  t32 = ua32 / ub32;
          3'b110:  t32 = sa32 % sb32;
          default: t32 = ua32 % ub32;
        endcase
      end
      res = {{32{t32[31]}}, t32};
      lat = special ? 1 : 33;
    end else begin
      if (b == 0) begin
        special = 1;
        t64 = f3[1] ? sa64 : -64'sd1;
      end else if (!f3[0] && a == 64'h8000_0000_0000_0000 && sb64 == -64'sd1) begin
        special = 1;
        t64 = f3[1] ? 64'sd0 : sa64;
      end else begin
        case (f3)
          3'b100:  t64 = sa64 / sb64;
          3'b101:  t64 = a / b;
          3'b110:  t64 = sa64 % sb64;
          default: t64 = a % b;
        endcase
      end
      res = t64;
      lat = special ? 1 : 65;
    end
  endtask

  task automatic start_op(input logic [2:0] f3, input logic w, input logic [63:0] a,
                          input logic [63:0] b);
    func3 = f3; w_en = w; rsA = a; rsB = b; en = 1'b1;
  endtask

  // Called in cycle 0; returns at the negedge of the ready cycle (lat=-1 on timeout).
  task automatic wait_ready(output int lat, output logic [63:0] res);
    lat = -1;
    res = '0;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (ready) begin
        lat = c;
        res = result;
        break;
      end
    end
    en = 1'b0;
  endtask

  task automatic run_op(input logic [2:0] f3, input logic w, input logic [63:0] a,
                        input logic [63:0] b, output int lat, output logic [63:0] res);
    @(negedge clk);
    start_op(f3, w, a, b);
    wait_ready(lat, res);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_cmp++;
    if (ready !== 1'b0 || busy !== 1'b0 || result !== 64'h0) begin
      n_err++;
      $display("FAIL reset_hold: ready=%b busy=%b result=%h, required 0/0/0", ready, busy, result);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (ready !== 1'b0 || busy !== 1'b0 || result !== 64'h0) begin
      n_err++;
      $display("FAIL reset_release: ready=%b busy=%b result=%h, required 0/0/0", ready, busy, result);
    end
    $display("reset: ready=%b busy=%b result=%h", ready, busy, result);
  endtask

  task automatic test_directed();
    vec_t v[13];
    int lat;
    logic [63:0] res;
    v = '{
      '{3'b101, 1'b0, 64'd100, 64'd7, 64'd14, 65},
      '{3'b111, 1'b0, 64'd100, 64'd7, 64'd2, 65},
      '{3'b100, 1'b0, -64'sd100, 64'd7, 64'hFFFF_FFFF_FFFF_FFF2, 65},
      '{3'b110, 1'b0, -64'sd100, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 65},
      '{3'b100, 1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1},
      '{3'b101, 1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1},
      '{3'b110, 1'b0, 64'd5, 64'd0, 64'd5, 1},
      '{3'b111, 1'b0, 64'd5, 64'd0, 64'd5, 1},
      '{3'b100, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1},
      '{3'b110, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1},
      '{3'b100, 1'b1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1},
      '{3'b111, 1'b1, 64'hDEAD_0000_FFFF_FFFF, 64'h10, 64'hF, 33},
      '{3'b101, 1'b1, 64'hDEAD_0000_FFFF_FFFF, 64'h10, 64'h0000_0000_0FFF_FFFF, 33}
    };
    foreach (v[i]) begin
      run_op(v[i].f3, v[i].w, v[i].a, v[i].b, lat, res);
      $display("directed %0d: f3=%b w=%b a=%h b=%h -> %h lat=%0d", i, v[i].f3, v[i].w,
               v[i].a, v[i].b, res, lat);
      n_cmp++;
      if (res !== v[i].exp) begin
        n_err++;
        $display("FAIL directed_result[%0d]: got %h, required %h", i, res, v[i].exp);
      end
      n_cmp++;
      if (lat != v[i].lat) begin
        n_err++;
        $display("FAIL directed_latency[%0d]: got %0d, required %0d", i, lat, v[i].lat);
      end
      last_exp = v[i].exp;
    end
  endtask

  task automatic test_random();
    logic [2:0] f3;
    logic w;
    logic [63:0] a, b, exp, res;
    int lat, exp_lat;
    for (int i = 0; i < 40; i++) begin
      f3 = 3'(4 + $urandom_range(0, 3));
      w  = 1'($urandom_range(0, 1));
      a  = {$urandom, $urandom};
      case ($urandom_range(0, 5))
        0: b = w ? {$urandom, 32'h0} : 64'h0;
        1: b = 64'hFFFF_FFFF_FFFF_FFFF;
        2: b = 64'($urandom_range(1, 20));
        3: b = {32'h0, $urandom};
        4: begin
          a = w ? {$urandom, 32'h8000_0000} : 64'h8000_0000_0000_0000;
          b = w ? {$urandom, 32'hFFFF_FFFF} : 64'hFFFF_FFFF_FFFF_FFFF;
        end
        default: b = {$urandom, $urandom};
      endcase
      ref_model(f3, w, a, b, exp, exp_lat);
      run_op(f3, w, a, b, lat, res);
      $display("random %0d: f3=%b w=%b a=%h b=%h -> %h lat=%0d", i, f3, w, a, b, res, lat);
      n_cmp++;
      if (res !== exp) begin
        n_err++;
        $display("FAIL random_result[%0d]: got %h, required %h", i, res, exp);
      end
      n_cmp++;
      if (lat != exp_lat) begin
        n_err++;
        $display("FAIL random_latency[%0d]: got %0d, required %0d", i, lat, exp_lat);
      end
      @(negedge clk);
      n_cmp++;
      if (ready !== 1'b0 || result !== exp) begin
        n_err++;
        $display("FAIL random_after_ready[%0d]: ready=%b result=%h, required 0 and %h", i, ready, result, exp);
      end
      last_exp = exp;
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [63:0] res;
    run_op(3'b101, 1'b0, 64'd1000, 64'd3, lat, res);
    run_op(3'b110, 1'b0, -64'sd1000, 64'd3, lat, res);
    $display("back_to_back: rem -1000/3 -> %h lat=%0d", res, lat);
    n_cmp++;
    if (res !== 64'hFFFF_FFFF_FFFF_FFFF || lat != 65) begin
      n_err++;
      $display("FAIL back_to_back_normal: got %h lat %0d, required ffffffffffffffff lat 65", res, lat);
    end
    run_op(3'b111, 1'b1, 64'd77, 64'd0, lat, res);
    run_op(3'b100, 1'b1, 64'hFFFF_FFF0, 64'd4, lat, res);
    $display("back_to_back: divw -16/4 -> %h lat=%0d", res, lat);
    n_cmp++;
    if (res !== 64'hFFFF_FFFF_FFFF_FFFC || lat != 33) begin
      n_err++;
      $display("FAIL back_to_back_after_special: got %h lat %0d, required fffffffffffffffc lat 33", res, lat);
    end
    last_exp = 64'hFFFF_FFFF_FFFF_FFFC;
  endtask

  task automatic test_operand_change();
    int lat;
    logic [63:0] res;
    @(negedge clk);
    start_op(3'b101, 1'b0, 64'd100, 64'd7);
    repeat (5) @(negedge clk);
    en = 1'b0; rsA = {$urandom, $urandom}; rsB = 64'd3; func3 = 3'b110; w_en = 1'b1;
    lat = -1;
    res = '0;
    for (int c = 6; c <= 200; c++) begin
      @(negedge clk);
      if (ready) begin
        lat = c;
        res = result;
        break;
      end
    end
    $display("operand_change: -> %h lat=%0d", res, lat);
    n_cmp++;
    if (res !== 64'd14 || lat != 65) begin
      n_err++;
      $display("FAIL operand_change: got %h lat %0d, required 000000000000000e lat 65", res, lat);
    end
    last_exp = 64'd14;
  endtask

  task automatic test_flush();
    int lat;
    logic [63:0] res;
    @(negedge clk);
    start_op(3'b101, 1'b0, 64'd100, 64'd7);
    repeat (20) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || ready !== 1'b0 || result !== last_exp) begin
      n_err++;
      $display("FAIL flush_abort: busy=%b ready=%b result=%h, required 0/0/%h", busy, ready, result, last_exp);
    end
    start_op(3'b101, 1'b0, 64'd9, 64'd2);
    wait_ready(lat, res);
    $display("flush: divu 9/2 after abort -> %h lat=%0d", res, lat);
    n_cmp++;
    if (res !== 64'd4 || lat != 65) begin
      n_err++;
      $display("FAIL flush_restart: got %h lat %0d, required 0000000000000004 lat 65", res, lat);
    end
    last_exp = 64'd4;
    // flush together with en in IDLE must not start anything
    @(negedge clk);
    start_op(3'b101, 1'b0, 64'd100, 64'd0);
    flush = 1'b1;
    @(negedge clk);
    en = 1'b0;
    flush = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || ready !== 1'b0 || result !== last_exp) begin
      n_err++;
      $display("FAIL flush_with_en: busy=%b ready=%b result=%h, required 0/0/%h", busy, ready, result, last_exp);
    end
    $display("flush_with_en: busy=%b ready=%b result=%h", busy, ready, result);
  endtask

  task automatic test_reset_mid();
    int pulses;
    @(negedge clk);
    start_op(3'b101, 1'b0, 64'd100, 64'd7);
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (ready !== 1'b0 || busy !== 1'b0 || result !== 64'h0) begin
      n_err++;
      $display("FAIL reset_mid_busy: ready=%b busy=%b result=%h, required 0/0/0", ready, busy, result);
    end
    en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    repeat (70) begin
      @(negedge clk);
      if (ready) pulses++;
    end
    $display("reset_mid: pulses=%0d result=%h", pulses, result);
    n_cmp++;
    if (pulses != 0 || result !== 64'h0) begin
      n_err++;
      $display("FAIL reset_mid_after: pulses=%0d result=%h, required 0 and 0", pulses, result);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_operand_change();
    test_flush();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
